fifo_parity_checker: RTL and testbench

Downstream consumer of the parity-protected FIFO. It pops `DATA_WIDTH+1`-bit words through the FIFO's pop handshake and checks each word's parity. It strips the parity bit and passes the data through a 2-entry output buffer to the next stage under valid/ready. Parity failures are counted and flagged, and optionally dropped.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/skid_buffer2.sv | 66 ++++++
 rtl/fifo_parity_checker.sv | 98 +++++++++
 tb/tb_fifo_parity_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parity-checking FIFO consumer.
// Helpers take words zero-extended to MaxWidth+1 bits so they work for any payload width.
package fifo_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} buf_state_t;

    // Zero-extension does not change the XOR reduction.
    function automatic logic parity_ok(input logic [MaxWidth:0] word, input logic even_odd);
        return (^word) == even_odd;
    endfunction

    // The caller truncates to the payload width, which removes a top parity bit.
    function automatic logic [MaxWidth:0] strip_parity(input logic [MaxWidth:0] word,
                                                       input logic parity_bit);
        return parity_bit ? word : (word >> 1);
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready buffer with strict FIFO order.
// The input side is ready whenever the buffer is not full; the head entry drives the output.
module skid_buffer2
    import fifo_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    buf_state_t       state_q;
    logic [Width-1:0] head_q;
    logic [Width-1:0] tail_q;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        in_ready_o  = (state_q != StFull);
        out_valid_o = (state_q != StEmpty);
        out_data_o  = head_q;
        in_fire     = in_valid_i && in_ready_o;
        out_fire    = out_valid_o && out_ready_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        head_q  <= in_data_i;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        head_q <= in_data_i;
                    end else if (in_fire) begin
                        tail_q  <= in_data_i;
                        state_q <= StFull;
                    end else if (out_fire) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        head_q  <= tail_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: rtl/fifo_parity_checker.sv
// Pops parity-protected words, checks and strips parity, and forwards payloads through a
// 2-entry buffer. Parity failures are counted (saturating), flagged sticky and optionally dropped.
module fifo_parity_checker
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          EVEN_ODD      = 1'b0,
    parameter bit          PARITY_BIT    = 1'b1,
    parameter bit          DROP_BAD      = 1'b0,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH:0]      pop_data_i,
    input  logic                     pop_valid_i,
    output logic                     pop_grant_o,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic                     out_err_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    input  logic                     clr_err_i,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic                     err_sticky_o
);

    logic [MaxWidth:0]      word_ext;
    logic [MaxWidth:0]      payload_ext;
    logic [DATA_WIDTH-1:0]  payload;
    logic                   unused_payload_hi;
    logic                   good;
    logic                   accept;
    logic                   bad_acc;
    logic                   buf_in_valid;
    logic                   buf_ready;
    logic [DATA_WIDTH:0]    buf_out;
    logic [ERR_CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                   sticky_d, sticky_q;

    always_comb begin
        word_ext                 = '0;
        word_ext[DATA_WIDTH:0]   = pop_data_i;
        good                     = parity_ok(word_ext, EVEN_ODD);
        payload_ext              = strip_parity(word_ext, PARITY_BIT);
        payload                  = payload_ext[DATA_WIDTH-1:0];
        unused_payload_hi        = ^payload_ext[MaxWidth:DATA_WIDTH];
        // Grant comes only from registered buffer state, gated off while in reset.
        pop_grant_o              = buf_ready && !rst;
        accept                   = pop_valid_i && pop_grant_o;
        bad_acc                  = accept && !good;
        buf_in_valid             = accept && (good || !DROP_BAD);
    end

    skid_buffer2 #(
        .Width (DATA_WIDTH + 1)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   ({!good, payload}),
        .in_valid_i  (buf_in_valid),
        .in_ready_o  (buf_ready),
        .out_data_o  (buf_out),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    assign out_err_o  = buf_out[DATA_WIDTH];
    assign out_data_o = buf_out[DATA_WIDTH-1:0];

    // A clear in the same cycle as a bad accept acts first, so the count restarts at one.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_err_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
        if (bad_acc) begin
            sticky_d = 1'b1;
            if (cnt_d != {ERR_CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_d + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign err_count_o  = cnt_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_fifo_parity_checker.sv
// Scoreboard bench: two checker instances (forwarding with a 2-bit counter, dropping with an
// 8-bit counter) share stimulus; a negedge monitor compares each against a queue-based model.
module tb_fifo_parity_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] pop_data;
    logic        pop_valid;
    logic        out_ready;
    logic        clr;

    logic        grant_f, err_f, valid_f, sticky_f;
    logic [31:0] data_f;
    logic [1:0]  cnt_f;
    logic        grant_d, err_d, valid_d, sticky_d;
    logic [31:0] data_d;
    logic [7:0]  cnt_d;

    logic        grant_a[2], err_a[2], valid_a[2], sticky_a[2];
    logic [31:0] data_a[2];
    logic [7:0]  cnt_a[2];

    typedef struct {logic [31:0] d; logic e;} exp_t;
    exp_t q[2][$];
    int   mcnt[2];
    bit   mst[2];
    int   cmax[2]  = '{3, 255};
    bit   dropb[2] = '{1'b0, 1'b1};

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int mon_n;
    bit mon_bad;
    exp_t mon_e;

    always #5 clk = ~clk;

    fifo_parity_checker #(
        .DATA_WIDTH(32), .EVEN_ODD(1'b0), .PARITY_BIT(1'b1), .DROP_BAD(1'b0), .ERR_CNT_WIDTH(2)
    ) u_fwd (
        .clk(clk), .rst(rst), .pop_data_i(pop_data), .pop_valid_i(pop_valid),
        .pop_grant_o(grant_f), .out_data_o(data_f), .out_err_o(err_f), .out_valid_o(valid_f),
        .out_ready_i(out_ready), .clr_err_i(clr), .err_count_o(cnt_f), .err_sticky_o(sticky_f)
    );

    fifo_parity_checker #(
        .DATA_WIDTH(32), .EVEN_ODD(1'b0), .PARITY_BIT(1'b1), .DROP_BAD(1'b1), .ERR_CNT_WIDTH(8)
    ) u_drop (
        .clk(clk), .rst(rst), .pop_data_i(pop_data), .pop_valid_i(pop_valid),
        .pop_grant_o(grant_d), .out_data_o(data_d), .out_err_o(err_d), .out_valid_o(valid_d),
        .out_ready_i(out_ready), .clr_err_i(clr), .err_count_o(cnt_d), .err_sticky_o(sticky_d)
    );

    assign grant_a[0] = grant_f;  assign grant_a[1] = grant_d;
    assign err_a[0]   = err_f;    assign err_a[1]   = err_d;
    assign valid_a[0] = valid_f;  assign valid_a[1] = valid_d;
    assign sticky_a[0] = sticky_f; assign sticky_a[1] = sticky_d;
    assign data_a[0]  = data_f;   assign data_a[1]  = data_d;
    assign cnt_a[0]   = {6'b0, cnt_f};
    assign cnt_a[1]   = cnt_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Even parity: the parity bit makes the total number of ones even; 'bad' flips it.
    function automatic logic [32:0] mk(input logic [31:0] d, input bit bad);
        return {(^d) ^ bad, d};
    endfunction

    // Monitor: compare current outputs with the model, then advance the model by the
    // transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                mon_n = q[i].size();
                chk($sformatf("valid%0d", i), {31'b0, valid_a[i]}, {31'b0, mon_n > 0});
                chk($sformatf("grant%0d", i), {31'b0, grant_a[i]}, {31'b0, !rst && mon_n < 2});
                chk($sformatf("count%0d", i), {24'b0, cnt_a[i]}, mcnt[i]);
                chk($sformatf("sticky%0d", i), {31'b0, sticky_a[i]}, {31'b0, mst[i]});
                if (valid_a[i] && mon_n > 0) begin
                    chk($sformatf("data%0d", i), data_a[i], q[i][0].d);
                    chk($sformatf("err%0d", i), {31'b0, err_a[i]}, {31'b0, q[i][0].e});
                end
                if (rst) begin
                    q[i].delete();
                    mcnt[i] = 0;
                    mst[i]  = 1'b0;
                end else begin
                    if (valid_a[i] && out_ready && mon_n > 0) void'(q[i].pop_front());
                    if (clr) begin
                        mcnt[i] = 0;
                        mst[i]  = 1'b0;
                    end
                    if (pop_valid && grant_a[i]) begin
                        mon_bad = (^pop_data) != 1'b0;
                        if (!mon_bad || !dropb[i]) begin
                            mon_e.d = pop_data[31:0];
                            mon_e.e = mon_bad;
                            q[i].push_back(mon_e);
                        end
                        if (mon_bad) begin
                            mst[i] = 1'b1;
                            if (mcnt[i] < cmax[i]) mcnt[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic push(input logic [32:0] w);
        int waited = 0;
        pop_data  = w;
        pop_valid = 1'b1;
        @(negedge clk);
        while (!grant_f && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk("push_grant", {31'b0, grant_f}, 32'd1);
        @(posedge clk);
        #1;
        pop_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pop_valid = 1'b1; pop_data = mk(32'h5, 1'b0); out_ready = 1'b1; clr = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_data", data_f, 32'h0);
        chk("rst_err", {31'b0, err_f}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; pop_valid = 1'b0;
        @(negedge clk);
        chk("grant_after_rst", {31'b0, grant_f}, 32'd1);
        @(posedge clk);
        #1;

        push(33'h1_0000_0001);
        push(33'h0_0000_0003);
        push(33'h0_0000_0001);
        push(33'h0_0000_0006);
        idle(3);
        chk("bad_cnt_fwd", {30'b0, cnt_f}, 32'd1);
        chk("bad_cnt_drop", {24'b0, cnt_d}, 32'd1);

        clr = 1'b1;
        idle(1);
        clr = 1'b0;

        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 30; k++) push(mk(32'(2 * k), 1'b0));
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_grant_low", {31'b0, grant_f}, 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 20 && valid_f; t++) idle(1);
        chk("bp_drained", {31'b0, valid_f}, 32'd0);

        for (int k = 0; k < 5; k++) push(mk(32'h100 + 32'(k), 1'b1));
        idle(2);
        chk("sat_cnt", {30'b0, cnt_f}, 32'd3);
        chk("sat_sticky", {31'b0, sticky_f}, 32'd1);
        clr = 1'b1;
        push(mk(32'h77, 1'b1));
        clr = 1'b0;
        idle(1);
        chk("clr_bad_cnt", {30'b0, cnt_f}, 32'd1);
        chk("clr_bad_sticky", {31'b0, sticky_f}, 32'd1);

        for (int c = 0; c < 400; c++) begin
            pop_valid = ($urandom % 4) != 0;
            pop_data  = {1'($urandom), 32'($urandom)};
            out_ready = ($urandom % 3) != 0;
            clr       = ($urandom % 40) == 0;
            rst       = ($urandom % 150) == 0;
            idle(1);
        end
        rst = 1'b0; pop_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        idle(6);
        chk("final_drain_fwd", {31'b0, valid_f}, 32'd0);
        chk("final_drain_drop", {31'b0, valid_d}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
